// File: rtl/gf4_pkg.sv
// Shared GF(2^4) definitions: field width, reduction polynomial and evaluator FSM states.
package gf4_pkg;

   localparam int unsigned GF_W     = 4;
   localparam logic [4:0]  GF4_POLY = 5'b10011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gf4_mul.sv
// Combinational GF(2^4) multiplier: carry-less product reduced modulo FIELD_POLY.
module gf4_mul
   import gf4_pkg::*;
#(
   parameter logic [4:0] FIELD_POLY = GF4_POLY
) (
   input  logic [GF_W-1:0] a,
   input  logic [GF_W-1:0] b,
   output logic [GF_W-1:0] p
);

   localparam int unsigned PROD_W = 2 * GF_W - 1;

   logic [PROD_W-1:0] prod;

   always_comb begin
      prod = '0;
      for (int i = 0; i < GF_W; i++) begin
         if (b[i]) prod = prod ^ (PROD_W'(a) << i);
      end
      // fold the high terms back down, highest degree first
      for (int i = PROD_W - 1; i >= GF_W; i--) begin
         if (prod[i]) prod = prod ^ (PROD_W'(FIELD_POLY) << (i - GF_W));
      end
      p = prod[GF_W-1:0];
   end

endmodule

// File: rtl/gf4_horner_eval.sv
// Streaming polynomial evaluator over GF(2^4) using Horner's rule, highest-degree coefficient first.
module gf4_horner_eval
   import gf4_pkg::*;
#(
   parameter logic [4:0] FIELD_POLY = GF4_POLY
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [GF_W-1:0] x_in,
   input  logic [3:0]      nterms,
   input  logic            coef_valid,
   input  logic [GF_W-1:0] coef_in,
   output logic            coef_ready,
   output logic            busy,
   output logic            done,
   output logic [GF_W-1:0] result
);

   state_t          state;
   logic [GF_W-1:0] acc;
   logic [GF_W-1:0] x_q;
   logic [3:0]      count;
   logic [GF_W-1:0] mul_p;
   logic [GF_W-1:0] acc_nxt;

   gf4_mul #(.FIELD_POLY(FIELD_POLY)) u_mul (
      .a (acc),
      .b (x_q),
      .p (mul_p)
   );

   assign acc_nxt = mul_p ^ coef_in;

   // Handshake and status flags are pure state decodes
   assign coef_ready = (state == ST_RUN);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         acc    <= '0;
         count  <= '0;
         x_q    <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x_q   <= x_in;
                  count <= nterms;
                  acc   <= '0;
                  if (nterms == 4'd0) begin
                     result <= '0;
                     state  <= ST_DONE;
                  end else begin
                     state  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (coef_valid) begin
                  acc   <= acc_nxt;
                  count <= count - 4'd1;
                  if (count == 4'd1) begin
                     result <= acc_nxt;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf4_horner_eval.sv
// Randomized self-checking bench for gf4_horner_eval and an exhaustive check of gf4_mul.
module tb_gf4_horner_eval;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] x_in = 4'd0;
   logic [3:0] nterms = 4'd0;
   logic       coef_valid = 1'b0;
   logic [3:0] coef_in = 4'd0;
   logic       coef_ready;
   logic       busy;
   logic       done;
   logic [3:0] result;

   logic [3:0] ma = 4'd0;
   logic [3:0] mb = 4'd0;
   logic [3:0] mp;

   int checks = 0;
   int failures = 0;

   logic [3:0] cv [16];
   logic [3:0] mtab [256];

   gf4_horner_eval dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x_in       (x_in),
      .nterms     (nterms),
      .coef_valid (coef_valid),
      .coef_in    (coef_in),
      .coef_ready (coef_ready),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   gf4_mul u_mul_chk (
      .a (ma),
      .b (mb),
      .p (mp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Shift-and-add multiply: doubling in GF(16) is shift left, xor 0x3 when x^3 falls off
   function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      logic [3:0] aa;
      r  = 4'd0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return r;
   endfunction

   // Direct sum of c[j] * x^(n-1-j)
   function automatic logic [3:0] ref_eval(input logic [3:0] x, input int n, input logic [3:0] c [16]);
      logic [3:0] r;
      logic [3:0] pw;
      r = 4'd0;
      for (int j = 0; j < n; j++) begin
         pw = 4'd1;
         for (int k = 0; k < n - 1 - j; k++) pw = ref_mul(pw, x);
         r = r ^ ref_mul(c[j], pw);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stall < 0 picks 0..2 idle cycles before each coefficient at random
   task automatic run_eval(input logic [3:0] x, input int n, input logic [3:0] c [16],
                           input logic [3:0] exp, input int stall, input bit noisy);
      int s;
      start      = 1'b1;
      x_in       = x;
      nterms     = 4'(n);
      coef_valid = 1'b0;
      tick();
      start  = 1'b0;
      x_in   = 4'($urandom);
      nterms = 4'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      if (n != 0) begin
         check("ready_in_run", 32'(coef_ready), 32'd1);
         check("no_early_done", 32'(done), 32'd0);
         for (int j = 0; j < n; j++) begin
            s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int k = 0; k < s; k++) begin
               coef_valid = 1'b0;
               coef_in    = 4'($urandom);
               start      = noisy;
               tick();
               check("stall_no_done", 32'(done), 32'd0);
               check("stall_ready", 32'(coef_ready), 32'd1);
            end
            coef_valid = 1'b1;
            coef_in    = c[j];
            start      = noisy;
            tick();
            coef_valid = 1'b0;
            start      = 1'b0;
            if (j < n - 1) check("mid_no_done", 32'(done), 32'd0);
         end
      end
      check("done_pulse", 32'(done), 32'd1);
      check("result", 32'(result), 32'(exp));
      check("ready_low_in_done", 32'(coef_ready), 32'd0);
      // stray coef_valid while leaving DONE must be ignored
      coef_valid = 1'b1;
      coef_in    = 4'($urandom);
      tick();
      coef_valid = 1'b0;
      check("done_single_cycle", 32'(done), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
      check("idle_ready_low", 32'(coef_ready), 32'd0);
      check("result_held", 32'(result), 32'(exp));
   endtask

   initial begin
      int n;
      logic [3:0] x;
      bit seen;

      // gf4_mul: all operand pairs against the reference
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ma = 4'(a);
            mb = 4'(b);
            #1;
            mtab[a * 16 + b] = mp;
            check("mul_ref", 32'(mp), 32'(ref_mul(4'(a), 4'(b))));
         end
      end
      for (int a = 0; a < 16; a++) begin
         check("mul_ident", 32'(mtab[a * 16 + 1]), 32'(a));
         for (int b = a + 1; b < 16; b++)
            check("mul_commute", 32'(mtab[a * 16 + b]), 32'(mtab[b * 16 + a]));
      end

      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(coef_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) cv[i] = 4'd0;

      cv[0] = 4'd1; cv[1] = 4'd1; cv[2] = 4'd1;
      run_eval(4'd3, 3, cv, 4'h7, 0, 1'b0);

      cv[0] = 4'd2; cv[1] = 4'd0;
      run_eval(4'd8, 2, cv, 4'h3, 0, 1'b0);

      run_eval(4'd5, 0, cv, 4'h0, 0, 1'b0);

      cv[0] = 4'd1; cv[1] = 4'd0; cv[2] = 4'd0;
      run_eval(4'd2, 3, cv, 4'h4, 3, 1'b1);

      // reset mid-run after one of three transfers, with start and coef_valid also high
      start = 1'b1; x_in = 4'd7; nterms = 4'd3;
      tick();
      start = 1'b0;
      coef_valid = 1'b1; coef_in = 4'd9;
      tick();
      rst = 1'b1; start = 1'b1; coef_valid = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; coef_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(coef_ready), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);

      cv[0] = 4'd1; cv[1] = 4'd1;
      run_eval(4'd2, 2, cv, 4'h3, 0, 1'b0);

      for (int r = 0; r < 24; r++) begin
         n = int'($urandom_range(0, 15));
         x = 4'($urandom);
         for (int i = 0; i < 16; i++) cv[i] = 4'($urandom);
         run_eval(x, n, cv, ref_eval(x, n, cv), -1, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
